// File: rtl/hsv2rgb_pkg.sv
// Shared constants and the hue-sector type for the hsv2rgb_stream converter.
package hsv2rgb_pkg;

   localparam int HUE_FULL   = 360;
   localparam int HUE_SECTOR = 60;
   localparam int RECIP60_K  = 1093;
   localparam int RECIP60_SH = 16;

   typedef enum logic [2:0] {
      SECTOR_0 = 3'd0,
      SECTOR_1 = 3'd1,
      SECTOR_2 = 3'd2,
      SECTOR_3 = 3'd3,
      SECTOR_4 = 3'd4,
      SECTOR_5 = 3'd5
   } sector_e;

   // Odd sectors run the fractional ramp downwards.
   function automatic logic sector_is_odd(input sector_e sec);
      return sec[0];
   endfunction

endpackage

// File: rtl/hsv_sector_decode.sv
// Hue wrap to 0..359 plus sector (h/60) and in-sector offset, registered on the stage-1 enable.
module hsv_sector_decode
   import hsv2rgb_pkg::*;
#(
   parameter int H_W = 9
)(
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic [H_W-1:0] h,
   output sector_e        sector_r,
   output logic [5:0]     f_r
);

   localparam int            HX     = H_W + 2;
   localparam logic [HX-1:0] FULL_X = HX'(HUE_FULL);
   localparam logic [8:0]    T1     = 9'(1 * HUE_SECTOR);
   localparam logic [8:0]    T2     = 9'(2 * HUE_SECTOR);
   localparam logic [8:0]    T3     = 9'(3 * HUE_SECTOR);
   localparam logic [8:0]    T4     = 9'(4 * HUE_SECTOR);
   localparam logic [8:0]    T5     = 9'(5 * HUE_SECTOR);

   logic [HX-1:0] h_x_s;
   logic [8:0]    h_wrap_s;
   sector_e       sector_s;
   logic [5:0]    f_s;

   assign h_x_s = HX'(h);

   if (H_W > 9) begin : g_wide
      localparam logic [HX-1:0] TWO_X = HX'(2 * HUE_FULL);
      // Wide hue: single subtract for the common case, modulo beyond two turns.
      always_comb begin
         if (h_x_s < FULL_X) begin
            h_wrap_s = 9'(h_x_s);
         end else if (h_x_s < TWO_X) begin
            h_wrap_s = 9'(h_x_s - FULL_X);
         end else begin
            h_wrap_s = 9'(h_x_s % FULL_X);
         end
      end
   end else begin : g_narrow
      // A 9-bit hue never reaches 720, so one subtract is enough.
      always_comb begin
         if (h_x_s < FULL_X) begin
            h_wrap_s = 9'(h_x_s);
         end else begin
            h_wrap_s = 9'(h_x_s - FULL_X);
         end
      end
   end

   // Compare chain picks the sector and the offset inside it.
   always_comb begin
      if (h_wrap_s >= T5) begin
         sector_s = SECTOR_5;
         f_s      = 6'(h_wrap_s - T5);
      end else if (h_wrap_s >= T4) begin
         sector_s = SECTOR_4;
         f_s      = 6'(h_wrap_s - T4);
      end else if (h_wrap_s >= T3) begin
         sector_s = SECTOR_3;
         f_s      = 6'(h_wrap_s - T3);
      end else if (h_wrap_s >= T2) begin
         sector_s = SECTOR_2;
         f_s      = 6'(h_wrap_s - T2);
      end else if (h_wrap_s >= T1) begin
         sector_s = SECTOR_1;
         f_s      = 6'(h_wrap_s - T1);
      end else begin
         sector_s = SECTOR_0;
         f_s      = 6'(h_wrap_s);
      end
   end

   // Stage-1 register for the decoded hue.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sector_r <= SECTOR_0;
         f_r      <= 6'd0;
      end else if (en) begin
         sector_r <= sector_s;
         f_r      <= f_s;
      end
   end

endmodule

// File: rtl/hsv2rgb_stream.sv
// Five-stage valid/ready HSV-to-RGB stream converter with delay-matched sideband.
// Optional sticky range_err output is enabled by defining HSV2RGB_RANGE_ERR_EN.
module hsv2rgb_stream
   import hsv2rgb_pkg::*;
#(
   parameter int PIX_W = 8,
   parameter int H_W   = 9,
   parameter int S_W   = 11,
   parameter int SB_W  = 3
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [H_W-1:0]   in_h,
   input  logic [S_W-1:0]   in_s,
   input  logic [PIX_W-1:0] in_v,
   input  logic [SB_W-1:0]  in_sb,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PIX_W-1:0] out_r,
   output logic [PIX_W-1:0] out_g,
   output logic [PIX_W-1:0] out_b,
   output logic [SB_W-1:0]  out_sb
`ifdef HSV2RGB_RANGE_ERR_EN
   ,
   output logic             range_err
`endif
);

   localparam int              PS_W   = PIX_W + S_W;
   localparam int              P_W    = PIX_W + 6;
   localparam int              X_W    = P_W + 11;
   localparam logic [S_W-1:0]  S_ONE  = {1'b1, {(S_W-1){1'b0}}};
   localparam logic [PS_W-1:0] C_RND  = PS_W'({2'b01, {(S_W-2){1'b0}}});
   localparam logic [5:0]      F_SPAN = 6'(HUE_SECTOR);

   logic             pipe_en_s;
   logic [S_W-1:0]   s_clamp_s;

   logic             s1_valid_r;
   sector_e          s1_sector_r;
   logic [5:0]       s1_f_r;
   logic [S_W-1:0]   s1_s_r;
   logic [PIX_W-1:0] s1_v_r;
   logic [SB_W-1:0]  s1_sb_r;

   logic             s2_valid_r;
   sector_e          s2_sector_r;
   logic [5:0]       s2_feff_r;
   logic [PIX_W-1:0] s2_c_r;
   logic [PIX_W-1:0] s2_v_r;
   logic [SB_W-1:0]  s2_sb_r;

   logic             s3_valid_r;
   sector_e          s3_sector_r;
   logic [PIX_W-1:0] s3_c_r;
   logic [PIX_W-1:0] s3_m_r;
   logic [P_W-1:0]   s3_p_r;
   logic [SB_W-1:0]  s3_sb_r;

   logic             s4_valid_r;
   sector_e          s4_sector_r;
   logic [PIX_W-1:0] s4_c_r;
   logic [PIX_W-1:0] s4_m_r;
   logic [PIX_W-1:0] s4_x_r;
   logic [SB_W-1:0]  s4_sb_r;

   logic [PIX_W-1:0] cm_s;
   logic [PIX_W-1:0] xm_s;
   logic [PIX_W-1:0] r_s;
   logic [PIX_W-1:0] g_s;
   logic [PIX_W-1:0] b_s;

   // Whole pipeline advances together; a stalled full output freezes every stage.
   assign pipe_en_s = out_ready | ~out_valid;
   assign in_ready  = pipe_en_s;

   // Saturation above 1.0 is clamped to 1.0.
   always_comb begin
      if (in_s > S_ONE) begin
         s_clamp_s = S_ONE;
      end else begin
         s_clamp_s = in_s;
      end
   end

   hsv_sector_decode #(
      .H_W      (H_W)
   ) u_sector_decode (
      .clk      (clk),
      .rst      (rst),
      .en       (pipe_en_s),
      .h        (in_h),
      .sector_r (s1_sector_r),
      .f_r      (s1_f_r)
   );

   // Stages 1-4: capture inputs, chroma, m/product, then X via reciprocal of 60.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_r  <= 1'b0;
         s1_s_r      <= '0;
         s1_v_r      <= '0;
         s1_sb_r     <= '0;
         s2_valid_r  <= 1'b0;
         s2_sector_r <= SECTOR_0;
         s2_feff_r   <= 6'd0;
         s2_c_r      <= '0;
         s2_v_r      <= '0;
         s2_sb_r     <= '0;
         s3_valid_r  <= 1'b0;
         s3_sector_r <= SECTOR_0;
         s3_c_r      <= '0;
         s3_m_r      <= '0;
         s3_p_r      <= '0;
         s3_sb_r     <= '0;
         s4_valid_r  <= 1'b0;
         s4_sector_r <= SECTOR_0;
         s4_c_r      <= '0;
         s4_m_r      <= '0;
         s4_x_r      <= '0;
         s4_sb_r     <= '0;
      end else if (pipe_en_s) begin
         s1_valid_r  <= in_valid;
         s1_s_r      <= s_clamp_s;
         s1_v_r      <= in_v;
         s1_sb_r     <= in_sb;

         s2_valid_r  <= s1_valid_r;
         s2_sector_r <= s1_sector_r;
         s2_feff_r   <= sector_is_odd(s1_sector_r) ? (F_SPAN - s1_f_r) : s1_f_r;
         s2_c_r      <= PIX_W'((PS_W'(s1_v_r) * PS_W'(s1_s_r) + C_RND) >> (S_W - 1));
         s2_v_r      <= s1_v_r;
         s2_sb_r     <= s1_sb_r;

         s3_valid_r  <= s2_valid_r;
         s3_sector_r <= s2_sector_r;
         s3_c_r      <= s2_c_r;
         s3_m_r      <= s2_v_r - s2_c_r;
         s3_p_r      <= P_W'(s2_c_r) * P_W'(s2_feff_r);
         s3_sb_r     <= s2_sb_r;

         s4_valid_r  <= s3_valid_r;
         s4_sector_r <= s3_sector_r;
         s4_c_r      <= s3_c_r;
         s4_m_r      <= s3_m_r;
         s4_x_r      <= PIX_W'((X_W'(s3_p_r) * X_W'(RECIP60_K)) >> RECIP60_SH);
         s4_sb_r     <= s3_sb_r;
      end
   end

   assign cm_s = s4_c_r + s4_m_r;
   assign xm_s = s4_x_r + s4_m_r;

   // Sector mux; both sums are bounded by V so no saturation is needed.
   always_comb begin
      case (s4_sector_r)
         SECTOR_0: begin r_s = cm_s;   g_s = xm_s;   b_s = s4_m_r; end
         SECTOR_1: begin r_s = xm_s;   g_s = cm_s;   b_s = s4_m_r; end
         SECTOR_2: begin r_s = s4_m_r; g_s = cm_s;   b_s = xm_s;   end
         SECTOR_3: begin r_s = s4_m_r; g_s = xm_s;   b_s = cm_s;   end
         SECTOR_4: begin r_s = xm_s;   g_s = s4_m_r; b_s = cm_s;   end
         SECTOR_5: begin r_s = cm_s;   g_s = s4_m_r; b_s = xm_s;   end
         default:  begin r_s = cm_s;   g_s = xm_s;   b_s = s4_m_r; end
      endcase
   end

   // Stage 5: registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_r     <= '0;
         out_g     <= '0;
         out_b     <= '0;
         out_sb    <= '0;
      end else if (pipe_en_s) begin
         out_valid <= s4_valid_r;
         out_r     <= r_s;
         out_g     <= g_s;
         out_b     <= b_s;
         out_sb    <= s4_sb_r;
      end
   end

`ifdef HSV2RGB_RANGE_ERR_EN
   localparam logic [H_W-1:0] H_LIMIT = H_W'(HUE_FULL);

   // Sticky flag: any accepted pixel with hue beyond 360 or saturation beyond 1.0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         range_err <= 1'b0;
      end else if (in_valid && pipe_en_s && ((in_h > H_LIMIT) || (in_s > S_ONE))) begin
         range_err <= 1'b1;
      end
   end
`endif

endmodule
